// File: rtl/gb_dma_engine_if.sv
// CPU register-window bus between the core and the DMA engine: byte-wide
// register reads/writes plus the stall request the engine raises during VRAM DMA.
interface gb_dma_engine_if;
    logic       cpu_sel_reg;
    logic [7:0] cpu_addr;
    logic       cpu_wr;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       cpu_stall;

    modport master (
        output cpu_sel_reg, cpu_addr, cpu_wr, cpu_di,
        input  cpu_do, cpu_stall
    );

    modport slave (
        input  cpu_sel_reg, cpu_addr, cpu_wr, cpu_di,
        output cpu_do, cpu_stall
    );
endinterface

// File: rtl/gb_dma_engine.sv
// OAM DMA (FF46, OAM_CLKS clocks/byte) and CGB VRAM DMA (FF51-FF55, 2 clocks/byte, GDMA/HDMA).
// Register reads are combinational; the CPU is held via cpu_stall while a VRAM block moves.
module gb_dma_engine #(
    parameter int OAM_LEN  = 160,
    parameter int OAM_CLKS = 4,
    parameter int BLK_LEN  = 16,
    parameter int VRAM_AW  = 13
) (
    input  logic               clk,
    input  logic               reset,
    gb_dma_engine_if.slave     cpu,
    input  logic               cgb_mode_i,
    input  logic [1:0]         ppu_mode_i,
    input  logic               lcd_on_i,
    output logic               oam_dma_active_o,
    output logic [15:0]        oam_src_o,
    input  logic [7:0]         oam_src_data_i,
    output logic               oam_wr_o,
    output logic [7:0]         oam_addr_o,
    output logic [7:0]         oam_di_o,
    output logic               vdma_rd_o,
    output logic [15:0]        vdma_src_o,
    input  logic [7:0]         vdma_src_data_i,
    output logic               vram_wr_o,
    output logic [VRAM_AW-1:0] vram_addr_o,
    output logic [7:0]         vram_di_o
);
    localparam int OCW = $clog2(OAM_LEN * OAM_CLKS);
    localparam int SHW = $clog2(OAM_CLKS);
    localparam int BCW = $clog2(BLK_LEN);
    localparam logic [OCW-1:0] OAM_LAST  = OCW'(OAM_LEN * OAM_CLKS - 1);
    localparam logic [SHW-1:0] OAM_WR_PH = SHW'(OAM_CLKS - 2);
    localparam logic [BCW-1:0] BLK_LAST  = BCW'(BLK_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_GDMA, S_HB_WAIT, S_HB_XFER} state_t;

    logic reg_wr, wr_46, vwr, wr_51, wr_52, wr_53, wr_54, wr_55;
    assign reg_wr = cpu.cpu_sel_reg && cpu.cpu_wr;
    assign wr_46  = reg_wr && (cpu.cpu_addr == 8'h46);
    assign vwr    = reg_wr && cgb_mode_i;
    assign wr_51  = vwr && (cpu.cpu_addr == 8'h51);
    assign wr_52  = vwr && (cpu.cpu_addr == 8'h52);
    assign wr_53  = vwr && (cpu.cpu_addr == 8'h53);
    assign wr_54  = vwr && (cpu.cpu_addr == 8'h54);
    assign wr_55  = vwr && (cpu.cpu_addr == 8'h55);

    // ---------------- OAM channel ----------------
    logic [7:0]     dma_hi_q, dma_hi_d;
    logic [OCW-1:0] oam_cnt_q, oam_cnt_d;
    logic           oam_act_q, oam_act_d;
    logic [7:0]     oam_idx;

    always_comb begin
        dma_hi_d  = dma_hi_q;
        oam_cnt_d = oam_cnt_q;
        oam_act_d = oam_act_q;
        if (wr_46) begin
            dma_hi_d  = cpu.cpu_di;
            oam_cnt_d = '0;
            oam_act_d = 1'b1;
        end else if (oam_act_q) begin
            if (oam_cnt_q == OAM_LAST) oam_act_d = 1'b0;
            else                       oam_cnt_d = oam_cnt_q + OCW'(1);
        end
    end

    assign oam_idx          = 8'(oam_cnt_q >> SHW);
    assign oam_dma_active_o = oam_act_q;
    assign oam_src_o        = {dma_hi_q, oam_idx};
    assign oam_addr_o       = oam_idx;
    assign oam_wr_o         = oam_act_q && (oam_cnt_q[SHW-1:0] == OAM_WR_PH);
    assign oam_di_o         = oam_wr_o ? oam_src_data_i : 8'h00;

    // ---------------- VRAM channel ----------------
    state_t             state_q, state_d;
    logic [15:0]        src_q, src_d;
    logic [VRAM_AW-1:0] dst_q, dst_d;
    logic [6:0]         len_q, len_d;
    logic [BCW-1:0]     bcnt_q, bcnt_d;
    logic               ph_q, ph_d;
    logic [7:0]         data_q, data_d;
    logic               cancel_q, cancel_d;
    logic               hb_prev_q, hb_now, xfer;

    assign hb_now = lcd_on_i && (ppu_mode_i == 2'b00);
    assign xfer   = (state_q == S_GDMA) || (state_q == S_HB_XFER);

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        bcnt_d   = bcnt_q;
        ph_d     = ph_q;
        data_d   = data_q;
        cancel_d = cancel_q;

        if (xfer) begin
            if (!ph_q) begin
                ph_d   = 1'b1;
                data_d = vdma_src_data_i;
            end else begin
                ph_d   = 1'b0;
                src_d  = src_q + 16'd1;
                dst_d  = dst_q + VRAM_AW'(1);
                bcnt_d = bcnt_q + BCW'(1);
                if (bcnt_q == BLK_LAST) begin
                    bcnt_d   = '0;
                    cancel_d = 1'b0;
                    if (len_q == 7'd0) begin
                        state_d = S_IDLE;
                        len_d   = 7'h7F;
                    end else begin
                        len_d = len_q - 7'd1;
                        if (state_q == S_HB_XFER) state_d = cancel_q ? S_IDLE : S_HB_WAIT;
                    end
                end
            end
        end else if (state_q == S_HB_WAIT && hb_now && !hb_prev_q) begin
            state_d = S_HB_XFER;
        end

        if (wr_51) src_d[15:8] = cpu.cpu_di;
        if (wr_52) src_d[7:0]  = {cpu.cpu_di[7:4], 4'h0};
        if (wr_53) dst_d       = VRAM_AW'({cpu.cpu_di[4:0], dst_q[7:0]});
        if (wr_54) dst_d       = {dst_q[VRAM_AW-1:8], cpu.cpu_di[7:4], 4'h0};

        // A GDMA in flight has the CPU stalled, so FF55 writes are only honoured otherwise.
        if (wr_55 && state_q != S_GDMA) begin
            if (cpu.cpu_di[7]) begin
                len_d    = cpu.cpu_di[6:0];
                bcnt_d   = '0;
                ph_d     = 1'b0;
                cancel_d = 1'b0;
                state_d  = lcd_on_i ? S_HB_WAIT : S_HB_XFER;
            end else if (state_q == S_IDLE) begin
                len_d   = cpu.cpu_di[6:0];
                bcnt_d  = '0;
                ph_d    = 1'b0;
                state_d = S_GDMA;
            end else if (state_d == S_HB_XFER) begin
                cancel_d = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dma_hi_q  <= 8'h00;
            oam_cnt_q <= '0;
            oam_act_q <= 1'b0;
            state_q   <= S_IDLE;
            src_q     <= 16'h0000;
            dst_q     <= '0;
            len_q     <= 7'h7F;
            bcnt_q    <= '0;
            ph_q      <= 1'b0;
            data_q    <= 8'h00;
            cancel_q  <= 1'b0;
            hb_prev_q <= 1'b0;
        end else begin
            dma_hi_q  <= dma_hi_d;
            oam_cnt_q <= oam_cnt_d;
            oam_act_q <= oam_act_d;
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            bcnt_q    <= bcnt_d;
            ph_q      <= ph_d;
            data_q    <= data_d;
            cancel_q  <= cancel_d;
            hb_prev_q <= hb_now;
        end
    end

    assign vdma_rd_o     = xfer && !ph_q;
    assign vdma_src_o    = src_q;
    assign vram_wr_o     = xfer && ph_q;
    assign vram_addr_o   = dst_q;
    assign vram_di_o     = data_q;
    assign cpu.cpu_stall = xfer;

    always_comb begin
        cpu.cpu_do = 8'hFF;
        if (cpu.cpu_sel_reg) begin
            if (cpu.cpu_addr == 8'h46)                    cpu.cpu_do = dma_hi_q;
            else if (cpu.cpu_addr == 8'h55 && cgb_mode_i) cpu.cpu_do = {state_q == S_IDLE, len_q};
        end
    end
endmodule

// File: tb/tb_gb_dma_engine.sv
// Bench for gb_dma_engine: register table, directed OAM/GDMA/HDMA/reset sequences,
// and randomized concurrent transfers compared against address-arithmetic expectations.
module tb_gb_dma_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gb_dma_engine_if bus();
    logic        cgb_mode;
    logic [1:0]  ppu_mode;
    logic        lcd_on;
    logic        oam_dma_active, oam_wr, vdma_rd, vram_wr;
    logic [15:0] oam_src, vdma_src;
    logic [7:0]  oam_src_data, oam_addr, oam_di, vdma_src_data, vram_di;
    logic [12:0] vram_addr;

    gb_dma_engine dut (
        .clk(clk), .reset(reset), .cpu(bus),
        .cgb_mode_i(cgb_mode), .ppu_mode_i(ppu_mode), .lcd_on_i(lcd_on),
        .oam_dma_active_o(oam_dma_active), .oam_src_o(oam_src), .oam_src_data_i(oam_src_data),
        .oam_wr_o(oam_wr), .oam_addr_o(oam_addr), .oam_di_o(oam_di),
        .vdma_rd_o(vdma_rd), .vdma_src_o(vdma_src), .vdma_src_data_i(vdma_src_data),
        .vram_wr_o(vram_wr), .vram_addr_o(vram_addr), .vram_di_o(vram_di)
    );

    // Source memories: byte value is a fixed function of its address.
    function automatic logic [7:0] oam_mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction
    function automatic logic [7:0] vsrc_mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction
    assign oam_src_data  = oam_mem(oam_src);
    assign vdma_src_data = vsrc_mem(vdma_src);

    logic [31:0] oam_log[$];
    logic [20:0] vram_log[$];
    int rd_cnt = 0, stall_cnt = 0, act_cnt = 0;
    always @(negedge clk) begin
        if (oam_wr)  oam_log.push_back({oam_addr, oam_src, oam_di});
        if (vram_wr) vram_log.push_back({vram_addr, vram_di});
        if (vdma_rd)        rd_cnt    <= rd_cnt + 1;
        if (bus.cpu_stall)  stall_cnt <= stall_cnt + 1;
        if (oam_dma_active) act_cnt   <= act_cnt + 1;
    end

    int checks = 0, failures = 0;
    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.cpu_sel_reg = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_di = d;
        @(posedge clk); #1;
        bus.cpu_sel_reg = 1'b0; bus.cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        bus.cpu_sel_reg = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = a;
        #3 d = bus.cpu_do;
        bus.cpu_sel_reg = 1'b0;
    endtask

    task automatic check_read(input string nm, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] r;
        cpu_read(a, r);
        check(nm, int'(r), int'(exp));
    endtask

    // OAM byte i of a transfer from page hi: index i, source {hi,i}, data from that source.
    task automatic check_oam(input int start, input int n, input logic [7:0] hi, input string nm);
        int mism = 0;
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            e = {8'(i), hi, 8'(i), oam_mem({hi, 8'(i)})};
            if (start + i >= oam_log.size()) mism++;
            else if (oam_log[start + i] !== e) mism++;
        end
        check({nm, "_data"}, mism, 0);
    endtask

    // VRAM byte i: destination d+i (13-bit wrap), data from source s+i (16-bit wrap).
    task automatic check_vram(input int start, input int n, input logic [15:0] s,
                              input logic [12:0] d, input string nm);
        int mism = 0;
        logic [20:0] e;
        check({nm, "_cnt"}, vram_log.size() - start, n);
        for (int i = 0; i < n; i++) begin
            e = {d + 13'(i), vsrc_mem(s + 16'(i))};
            if (start + i >= vram_log.size()) mism++;
            else if (vram_log[start + i] !== e) mism++;
        end
        check({nm, "_data"}, mism, 0);
    endtask

    typedef struct {
        logic       cgb;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdat;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[12];

    initial begin
        logic [15:0] msrc;
        logic [12:0] mdst;
        logic [7:0]  hi, rd;
        int s1, s2, a0, v0, r0, st0, n, len;
        bit oam_en;

        vecs[0]  = '{1'b1, 1'b0, 8'h46, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h51, 8'h00, 8'hFF};
        vecs[2]  = '{1'b1, 1'b0, 8'h52, 8'h00, 8'hFF};
        vecs[3]  = '{1'b1, 1'b0, 8'h53, 8'h00, 8'hFF};
        vecs[4]  = '{1'b1, 1'b0, 8'h54, 8'h00, 8'hFF};
        vecs[5]  = '{1'b1, 1'b0, 8'h55, 8'h00, 8'hFF};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[7]  = '{1'b1, 1'b0, 8'h47, 8'h00, 8'hFF};
        vecs[8]  = '{1'b1, 1'b1, 8'h51, 8'h12, 8'hFF};
        vecs[9]  = '{1'b1, 1'b1, 8'h53, 8'hFF, 8'hFF};
        vecs[10] = '{1'b0, 1'b1, 8'h55, 8'h00, 8'hFF};
        vecs[11] = '{1'b0, 1'b0, 8'h46, 8'h00, 8'h00};

        bus.cpu_sel_reg = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_di = 8'h00;
        cgb_mode = 1'b1; ppu_mode = 2'b10; lcd_on = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_outs", int'({bus.cpu_stall, oam_dma_active, oam_wr, vdma_rd, vram_wr,
                                  oam_src, oam_addr, oam_di, vdma_src, vram_addr, vram_di} != 0), 0);

        for (int i = 0; i < 12; i++) begin
            cgb_mode = vecs[i].cgb;
            if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].wdat);
            cpu_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), int'(rd), int'(vecs[i].exp));
        end
        cgb_mode = 1'b1;

        // OAM DMA from 0xC100
        s1 = oam_log.size(); a0 = act_cnt;
        cpu_write(8'h46, 8'hC1);
        check("oam_active_next", int'(oam_dma_active), 1);
        repeat (700) @(posedge clk); #1;
        check("oam_active_len", act_cnt - a0, 640);
        check("oam_wr_cnt", oam_log.size() - s1, 160);
        check_oam(s1, 160, 8'hC1, "oam1");
        check_read("oam_rd46", 8'h46, 8'hC1);

        // OAM restart 100 clocks into a transfer
        s1 = oam_log.size();
        cpu_write(8'h46, 8'hC0);
        repeat (98) @(posedge clk);
        cpu_write(8'h46, 8'hD0);
        s2 = oam_log.size(); a0 = act_cnt;
        n = 0;
        for (int c = 0; c < 100; c++) if (c % 4 == 2) n++;
        check("oam_pre_cnt", s2 - s1, n);
        check_oam(s1, n, 8'hC0, "oam_pre");
        repeat (700) @(posedge clk); #1;
        check("oam_restart_len", act_cnt - a0, 640);
        check("oam_restart_cnt", oam_log.size() - s2, 160);
        check_oam(s2, 160, 8'hD0, "oam_restart");

        // GDMA, 2 blocks
        msrc = 16'h4000; mdst = 13'h0800;
        cpu_write(8'h51, 8'h40); cpu_write(8'h52, 8'h00);
        cpu_write(8'h53, 8'h08); cpu_write(8'h54, 8'h00);
        v0 = vram_log.size(); st0 = stall_cnt;
        cpu_write(8'h55, 8'h01);
        check("gdma_stall_next", int'(bus.cpu_stall), 1);
        repeat (80) @(posedge clk); #1;
        check("gdma_stall_len", stall_cnt - st0, 64);
        check_vram(v0, 32, msrc, mdst, "gdma");
        msrc += 16'd32; mdst += 13'd32;
        check_read("gdma_rd55", 8'h55, 8'hFF);

        // HDMA, 3 blocks
        lcd_on = 1'b1; ppu_mode = 2'b11;
        v0 = vram_log.size();
        cpu_write(8'h55, 8'h82);
        repeat (10) @(posedge clk); #1;
        check("hdma_wait_nowr", vram_log.size() - v0, 0);
        check_read("hdma_rd_start", 8'h55, 8'h02);
        for (int k = 0; k < 3; k++) begin
            v0 = vram_log.size();
            ppu_mode = 2'b00;
            repeat (50) @(posedge clk); #1;
            check_vram(v0, 16, msrc, mdst, $sformatf("hdma_blk%0d", k));
            msrc += 16'd16; mdst += 13'd16;
            check_read($sformatf("hdma_rd%0d", k), 8'h55, (k == 2) ? 8'hFF : 8'(1 - k));
            ppu_mode = 2'b11;
            repeat (5) @(posedge clk);
        end

        // HDMA cancel after one block; VBlank never triggers
        cpu_write(8'h55, 8'h85);
        v0 = vram_log.size();
        ppu_mode = 2'b00; repeat (45) @(posedge clk);
        ppu_mode = 2'b11; repeat (3) @(posedge clk); #1;
        check_vram(v0, 16, msrc, mdst, "cancel_blk");
        msrc += 16'd16; mdst += 13'd16;
        check_read("cancel_rd_pre", 8'h55, 8'h04);
        cpu_write(8'h55, 8'h00);
        check_read("cancel_rd55", 8'h55, 8'h84);
        v0 = vram_log.size();
        for (int k = 0; k < 2; k++) begin
            ppu_mode = 2'b00; repeat (40) @(posedge clk);
            ppu_mode = 2'b01; repeat (40) @(posedge clk);
        end
        #1 check("cancel_no_wr", vram_log.size() - v0, 0);

        // cgb_mode=0 gating, then reset mid-GDMA
        cgb_mode = 1'b0;
        r0 = rd_cnt;
        cpu_write(8'h55, 8'h00);
        repeat (10) @(posedge clk); #1;
        check("nocgb_no_rd", rd_cnt - r0, 0);
        check_read("nocgb_rd55", 8'h55, 8'hFF);
        cgb_mode = 1'b1;
        cpu_write(8'h55, 8'h03);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_stall", int'(bus.cpu_stall), 0);
        check("rst_vram_wr", int'(vram_wr), 0);
        v0 = vram_log.size(); r0 = rd_cnt;
        repeat (2) @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk); #1;
        check("rst_no_wr", vram_log.size() - v0, 0);
        check("rst_no_rd", rd_cnt - r0, 0);
        check_read("rst_rd55", 8'h55, 8'hFF);
        check_read("rst_rd46", 8'h46, 8'h00);

        // Randomized GDMA with optional concurrent OAM DMA
        lcd_on = 1'b0;
        for (int it = 0; it < 6; it++) begin
            hi     = 8'($urandom);
            msrc   = {8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 4'h0};
            mdst   = {9'($urandom_range(0, 511)), 4'h0};
            if (it == 1) msrc = 16'hFFF0;
            if (it == 2) mdst = 13'h1FF0;
            len    = $urandom_range(0, 2);
            oam_en = (it % 2 == 0) || ($urandom_range(0, 1) == 1);
            s1 = oam_log.size(); v0 = vram_log.size(); st0 = stall_cnt;
            if (oam_en) cpu_write(8'h46, hi);
            cpu_write(8'h51, msrc[15:8]);
            cpu_write(8'h52, {msrc[7:4], 4'($urandom)});
            cpu_write(8'h53, {3'($urandom), mdst[12:8]});
            cpu_write(8'h54, {mdst[7:4], 4'($urandom)});
            cpu_write(8'h55, {1'b0, 7'(len)});
            repeat (oam_en ? 700 : (len + 1) * 32 + 20) @(posedge clk); #1;
            check_vram(v0, (len + 1) * 16, msrc, mdst, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_stall", it), stall_cnt - st0, (len + 1) * 32);
            check_read($sformatf("rnd%0d_rd55", it), 8'h55, 8'hFF);
            if (oam_en) begin
                check($sformatf("rnd%0d_oam_cnt", it), oam_log.size() - s1, 160);
                check_oam(s1, 160, hi, $sformatf("rnd%0d_oam", it));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
